// File: rtl/instr_fetch_unit.sv
// Program-ROM fetcher: drives the PC as ROM address, buffers fetched words in a
// 2-entry FIFO and hands them to the decoder over a valid/ready handshake.
module instr_fetch_unit #(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] HALT_WORD  = 16'h0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] value,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  jump_en,
  input  logic [ADDR_WIDTH-1:0] jump_addr,
  output logic                  halted
);

  // state | meaning
  // RUN   | fetching one word per cycle while the buffer has room
  // HALT  | halt word fetched; buffer drains, only a jump resumes fetching
  typedef enum logic {RUN, HALT} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] w0_q, w1_q, w0_d, w1_d;
  logic [ADDR_WIDTH-1:0] p0_q, p1_q, p0_d, p1_d;
  logic [1:0]            count_q, count_d;
  logic [1:0]            count_after_pop;
  logic                  pop;
  logic                  fetch;

  assign instr_valid = (count_q != 2'd0);
  assign address     = pc_q;
  assign instr       = instr_valid ? w0_q : '0;
  assign instr_pc    = instr_valid ? p0_q : '0;
  assign halted      = (state_q == HALT);

  // pop is gated by instr_valid so an undriven ready on an empty buffer is harmless
  assign pop   = instr_valid & instr_ready;
  assign fetch = (state_q == RUN) & ((count_q < 2'd2) | pop) & ~jump_en;

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    w0_d            = w0_q;
    w1_d            = w1_q;
    p0_d            = p0_q;
    p1_d            = p1_q;
    count_d         = count_q;
    count_after_pop = count_q - {1'b0, pop};
    if (jump_en) begin
      count_d = 2'd0;
      pc_d    = jump_addr;
      state_d = RUN;
    end else begin
      if (pop) begin
        w0_d = w1_q;
        p0_d = p1_q;
      end
      if (fetch) begin
        if (count_after_pop == 2'd0) begin
          w0_d = value;
          p0_d = pc_q;
        end else begin
          w1_d = value;
          p1_d = pc_q;
        end
        pc_d = pc_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        if (value == HALT_WORD) state_d = HALT;
      end
      count_d = count_after_pop + {1'b0, fetch};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= '0;
      w0_q    <= '0;
      w1_q    <= '0;
      p0_q    <= '0;
      p1_q    <= '0;
      count_q <= 2'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      w0_q    <= w0_d;
      w1_q    <= w1_d;
      p0_q    <= p0_d;
      p1_q    <= p1_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: ROM model plus a queue-based reference of the
// fetch buffer, directed scenarios and a randomized run.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [7:0]  address;
  logic [15:0] value;
  logic [15:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        jump_en;
  logic [7:0]  jump_addr;
  logic        halted;

  logic [15:0] rom [256];
  logic [15:0] plan [7] = '{16'h1003, 16'hFFFF, 16'hFFFF, 16'h4001, 16'h5200, 16'h1003, 16'h0000};
  logic [7:0]  wrap_pc [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};

  logic [23:0] mq [$];
  logic [7:0]  m_pc;
  logic        m_halt;

  int vectors = 0;
  int miscompares = 0;

  logic [33:0] obs;
  assign obs   = {instr_valid, instr, instr_pc, address, halted};
  assign value = rom[address];

  instr_fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .address     (address),
    .value       (value),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .jump_en     (jump_en),
    .jump_addr   (jump_addr),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [33:0] exp_vec();
    if (mq.size() == 0) return {1'b0, 16'h0000, 8'h00, m_pc, m_halt};
    return {1'b1, mq[0][23:8], mq[0][7:0], m_pc, m_halt};
  endfunction

  task automatic m_reset();
    mq.delete();
    m_pc   = 8'h00;
    m_halt = 1'b0;
  endtask

  task automatic load_plan_rom();
    for (int i = 0; i < 256; i++) begin
      rom[i] = 16'($urandom_range(16'hFFFF, 1));
    end
    for (int i = 0; i < 7; i++) rom[i] = plan[i];
  endtask

  // Applies inputs for one cycle and advances the reference by the same edge.
  task automatic drive_step(input logic rdy, input logic jen, input logic [7:0] ja);
    bit          pop;
    bit          fetch;
    logic [15:0] w;
    instr_ready = rdy;
    jump_en     = jen;
    jump_addr   = ja;
    if (jen) begin
      mq.delete();
      m_pc   = ja;
      m_halt = 1'b0;
    end else begin
      pop   = (mq.size() > 0) && (rdy === 1'b1);
      fetch = !m_halt && ((mq.size() < 2) || pop);
      if (pop) void'(mq.pop_front());
      if (fetch) begin
        w = rom[m_pc];
        mq.push_back({w, m_pc});
        if (w == 16'h0000) m_halt = 1'b1;
        m_pc = m_pc + 8'd1;
      end
    end
    @(posedge clk);
    #1;
    jump_en = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    instr_ready = 1'b1;
    jump_en     = 1'b0;
    jump_addr   = 8'h00;
    m_reset();
    #3;
    vectors++;
    if (obs !== 34'h0) begin
      miscompares++;
      $display("FAIL reset_async: got %h expected %h", obs, 34'h0);
    end
    @(posedge clk); #1;
    vectors++;
    if (obs !== exp_vec()) begin
      miscompares++;
      $display("FAIL reset_hold: got %h expected %h", obs, exp_vec());
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    for (int i = 0; i < 11; i++) begin
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL stream cyc%0d: got %h expected %h", i, obs, exp_vec());
      end
      if (i >= 1 && i <= 7) begin
        vectors++;
        if (instr !== plan[i-1] || instr_pc !== 8'(i-1) || instr_valid !== 1'b1) begin
          miscompares++;
          $display("FAIL stream_word cyc%0d: got %h@%h v%b expected %h@%h v1",
                   i, instr, instr_pc, instr_valid, plan[i-1], 8'(i-1));
        end
      end
      drive_step(1'b1, 1'b0, 8'h00);
    end
    vectors++;
    if ({halted, address, instr_valid} !== {1'b1, 8'h07, 1'b0}) begin
      miscompares++;
      $display("FAIL stream_halt: got halted=%b addr=%h valid=%b expected 1 07 0",
               halted, address, instr_valid);
    end
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL stall cyc%0d: got %h expected %h", i, obs, exp_vec());
      end
      drive_step(1'b0, 1'b0, 8'h00);
    end
    vectors++;
    if ({instr_valid, instr, instr_pc, address} !== {1'b1, 16'h1003, 8'h00, 8'h02}) begin
      miscompares++;
      $display("FAIL stall_hold: got v%b %h@%h addr=%h expected v1 1003@00 addr=02",
               instr_valid, instr, instr_pc, address);
    end
    for (int i = 0; i < 10; i++) begin
      drive_step(1'b1, 1'b0, 8'h00);
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL stall_resume cyc%0d: got %h expected %h", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_jump_full();
    do_reset();
    for (int i = 0; i < 3; i++) drive_step(1'b0, 1'b0, 8'h00);
    vectors++;
    if (obs !== exp_vec()) begin
      miscompares++;
      $display("FAIL jump_prefill: got %h expected %h", obs, exp_vec());
    end
    drive_step(1'b1, 1'b1, 8'h03);
    vectors++;
    if (instr_valid !== 1'b0 || address !== 8'h03) begin
      miscompares++;
      $display("FAIL jump_flush: got valid=%b addr=%h expected 0 03", instr_valid, address);
    end
    drive_step(1'bx, 1'b0, 8'h00);
    vectors++;
    if ({instr_valid, instr, instr_pc} !== {1'b1, 16'h4001, 8'h03}) begin
      miscompares++;
      $display("FAIL jump_target: got v%b %h@%h expected v1 4001@03", instr_valid, instr, instr_pc);
    end
    for (int i = 0; i < 6; i++) begin
      drive_step(1'b1, 1'b0, 8'h00);
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL jump_stream cyc%0d: got %h expected %h", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_halt_recover();
    vectors++;
    if (halted !== 1'b1) begin
      miscompares++;
      $display("FAIL recover_pre: got halted=%b expected 1", halted);
    end
    drive_step(1'b1, 1'b1, 8'h00);
    vectors++;
    if ({halted, instr_valid} !== 2'b00) begin
      miscompares++;
      $display("FAIL recover_jump: got halted=%b valid=%b expected 0 0", halted, instr_valid);
    end
    drive_step(1'b1, 1'b0, 8'h00);
    vectors++;
    if ({instr_valid, instr, instr_pc, halted} !== {1'b1, 16'h1003, 8'h00, 1'b0}) begin
      miscompares++;
      $display("FAIL recover_word: got v%b %h@%h h%b expected v1 1003@00 h0",
               instr_valid, instr, instr_pc, halted);
    end
    for (int i = 0; i < 8; i++) begin
      drive_step(1'b1, 1'b0, 8'h00);
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL recover_stream cyc%0d: got %h expected %h", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 256; i++) rom[i] = 16'($urandom_range(16'hFFFF, 1));
    drive_step(1'b1, 1'b1, 8'hFE);
    for (int i = 0; i < 4; i++) begin
      drive_step(1'b1, 1'b0, 8'h00);
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL wrap cyc%0d: got %h expected %h", i, obs, exp_vec());
      end
      vectors++;
      if (instr_pc !== wrap_pc[i] || instr_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL wrap_pc cyc%0d: got %h v%b expected %h v1", i, instr_pc, instr_valid, wrap_pc[i]);
      end
    end
  endtask

  task automatic test_random();
    logic       rdy;
    logic       jen;
    logic [7:0] ja;
    for (int i = 0; i < 256; i++) begin
      rom[i] = 16'($urandom_range(16'hFFFF, 1));
      if ($urandom_range(7) == 0) rom[i] = 16'h0000;
    end
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rdy = ($urandom_range(3) != 0);
      jen = ($urandom_range(9) == 0);
      ja  = 8'($urandom_range(255));
      drive_step(rdy, jen, ja);
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL random cyc%0d: got %h expected %h", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    load_plan_rom();
    drive_step(1'b1, 1'b1, 8'h00);
    for (int i = 0; i < 7; i++) drive_step(1'b1, 1'b0, 8'h00);
    vectors++;
    if ({instr_valid, halted, address} !== {1'b1, 1'b1, 8'h07}) begin
      miscompares++;
      $display("FAIL areset_pre: got v%b h%b addr=%h expected v1 h1 addr=07",
               instr_valid, halted, address);
    end
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    vectors++;
    if ({instr_valid, address, halted, instr} !== 26'h0) begin
      miscompares++;
      $display("FAIL areset_now: got v%b addr=%h h%b instr=%h expected all 0",
               instr_valid, address, halted, instr);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_step(1'b1, 1'b0, 8'h00);
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL areset_after cyc%0d: got %h expected %h", i, obs, exp_vec());
      end
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    instr_ready = 1'b0;
    jump_en     = 1'b0;
    jump_addr   = 8'h00;
    load_plan_rom();
    test_reset();
    test_stream();
    test_stall();
    test_jump_full();
    test_halt_recover();
    test_wrap();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
